// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (define PS2_TX_RETRY_EN for one automatic retry per command)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd,
    output logic       ready,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, ACK, WAITIDLE, FINISH} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_bit, w_bit;
    logic [7:0]    r_cmd, w_cmd;
    logic          r_par, w_par;
    logic          r_clk_oe, w_clk_oe;
    logic          r_dat_oe, w_dat_oe;
    logic          r_done, w_done;
    logic          r_error, w_error;
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_prev;
    logic          w_fall, w_fail;
`ifdef PS2_TX_RETRY_EN
    logic          r_retry, w_retry;
`endif

    assign w_fall     = r_clk_prev & ~r_clk_sync[1];
    assign ready      = (r_state == IDLE);
    assign done       = r_done;
    assign error      = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

    // two-flop synchronizers on the raw lines plus clock history for falling-edge detection
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    // state, shared inhibit/watchdog counter, frame data and registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_cmd    <= '0;
            r_par    <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_retry  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_cmd    <= w_cmd;
            r_par    <= w_par;
            r_clk_oe <= w_clk_oe;
            r_dat_oe <= w_dat_oe;
            r_done   <= w_done;
            r_error  <= w_error;
`ifdef PS2_TX_RETRY_EN
            r_retry  <= w_retry;
`endif
        end
    end

    // next-state, line drive and failure handling
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bit    = r_bit;
        w_cmd    = r_cmd;
        w_par    = r_par;
        w_clk_oe = r_clk_oe;
        w_dat_oe = r_dat_oe;
        w_done   = 1'b0;
        w_error  = 1'b0;
        w_fail   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry  = r_retry;
`endif
        case (r_state)
            IDLE: begin
                w_clk_oe = 1'b0;
                w_dat_oe = 1'b0;
                if (send) begin
                    w_cmd    = cmd;
                    w_par    = ~^cmd;
                    w_cnt    = '0;
                    w_clk_oe = 1'b1;
                    w_state  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    w_retry  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_state  = RTS;
                    w_clk_oe = 1'b0;
                    w_dat_oe = 1'b1;
                    w_cnt    = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RTS: begin
                w_state = XFER;
                w_bit   = '0;
                w_cnt   = '0;
            end
            XFER: begin
                if (w_fall) begin
                    w_bit    = r_bit + 4'd1;
                    w_dat_oe = (r_bit < 4'd8) ? ~r_cmd[r_bit[2:0]] : (r_bit == 4'd8) ? ~r_par : 1'b0;
                    w_state  = (r_bit == 4'd9) ? ACK : XFER;
                end
            end
            ACK: begin
                if (w_fall) begin
                    w_fail  = r_dat_sync[1];
                    w_state = r_dat_sync[1] ? ACK : WAITIDLE;
                end
            end
            WAITIDLE: w_state = (r_clk_sync[1] & r_dat_sync[1]) ? FINISH : WAITIDLE;
            FINISH: begin
                w_done  = 1'b1;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
        if (r_state == XFER || r_state == ACK || r_state == WAITIDLE) begin
            w_cnt  = w_fall ? '0 : r_cnt + 1'b1;
            w_fail = w_fail | (~w_fall & (r_cnt == TO_LAST));
        end
        if (w_fail) begin
            w_dat_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
            w_retry  = 1'b1;
            w_error  = r_retry;
            w_state  = r_retry ? IDLE : INHIBIT;
            w_clk_oe = ~r_retry;
            w_cnt    = '0;
`else
            w_error  = 1'b1;
            w_state  = IDLE;
            w_clk_oe = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench with a PS/2 device model and frame reference
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int TO  = 400;
    localparam int H   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       ready, done, error, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50(clk), .reset(rst_n), .send(send), .cmd(cmd),
        .ready(ready), .done(done), .error(error),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    // line frame as seen by the device: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] exp_frame(input logic [7:0] c);
        int ones;
        ones = $countones(c);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, c, 1'b0};
    endfunction

    task automatic do_send(input logic [7:0] c);
        @(negedge clk);
        cmd = c;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_rts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 50; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_dat_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] fr, output bit ok);
        fr = '0;
        wait_rts(ok);
        if (!ok) return;
        repeat (H) @(negedge clk);
        fr[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            fr[k] = ps2_dat_in;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic wait_result(input int d0, input int e0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
        checks++; if (ps2_dat_oe !== 1'b0) begin failures++; $display("FAIL reset_dat_oe got=%b exp=0", ps2_dat_oe); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", done, error); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ed;
        logic [10:0] fr;
        bit ok, got;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        do_send(8'hED);
        dev_frame(1'b1, fr, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ed_rts got=none exp=rts"); end
        checks++; if (fr !== exp_frame(8'hED)) begin failures++; $display("FAIL ed_frame got=%h exp=%h", fr, exp_frame(8'hED)); end
        wait_result(d0, e0, got);
        checks++; if (!got) begin failures++; $display("FAIL ed_result got=none exp=done"); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ed_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (err_cnt != e0) begin failures++; $display("FAIL ed_error got=%0d exp=0", err_cnt - e0); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ed_ready got=%b exp=1", ready); end
    endtask

    task automatic test_inhibit;
        logic [10:0] fr;
        bit ok, got;
        int n, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        do_send(8'h01);
        n = 0;
        while (ps2_clk_oe && n < INH + 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != INH) begin failures++; $display("FAIL inhibit_len got=%0d exp=%0d", n, INH); end
        dev_frame(1'b1, fr, ok);
        checks++; if (fr[9] !== 1'b0) begin failures++; $display("FAIL inhibit_parity got=%b exp=0", fr[9]); end
        checks++; if (fr !== exp_frame(8'h01)) begin failures++; $display("FAIL inhibit_frame got=%h exp=%h", fr, exp_frame(8'h01)); end
        wait_result(d0, e0, got);
        checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin failures++; $display("FAIL inhibit_done got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_random;
        logic [10:0] fr;
        logic [7:0] c;
        bit ok, got;
        int d0, e0;
        for (int t = 0; t < 5; t++) begin
            c = 8'($urandom_range(0, 255));
            d0 = done_cnt; e0 = err_cnt;
            do_send(c);
            dev_frame(1'b1, fr, ok);
            checks++; if (fr !== exp_frame(c)) begin failures++; $display("FAIL rand_frame cmd=%h got=%h exp=%h", c, fr, exp_frame(c)); end
            wait_result(d0, e0, got);
            checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin failures++; $display("FAIL rand_done cmd=%h got=%0d/%0d exp=1/0", c, done_cnt - d0, err_cnt - e0); end
        end
    endtask

    task automatic test_nack;
        logic [10:0] fr;
        logic [7:0] c;
        bit ok, got;
        int d0, e0;
        c = 8'($urandom_range(0, 255));
        d0 = done_cnt; e0 = err_cnt;
        do_send(c);
        dev_frame(1'b0, fr, ok);
`ifdef PS2_TX_RETRY_EN
        checks++; if (err_cnt != e0) begin failures++; $display("FAIL nack_first_error got=%0d exp=0", err_cnt - e0); end
        dev_frame(1'b0, fr, ok);
        checks++; if (fr !== exp_frame(c)) begin failures++; $display("FAIL nack_retry_frame got=%h exp=%h", fr, exp_frame(c)); end
`endif
        wait_result(d0, e0, got);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL nack_error got=%0d exp=1", err_cnt - e0); end
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL nack_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin failures++; $display("FAIL nack_idle got=%b%b%b exp=100", ready, ps2_clk_oe, ps2_dat_oe); end
    endtask

    task automatic test_timeout;
        bit prev, hit, nxt;
        int inh, t_rts, lat, exp_inh;
        logic oe_at_err;
        prev = 1'b0; hit = 1'b0; inh = 0; t_rts = 0; lat = 0; oe_at_err = 1'b1;
`ifdef PS2_TX_RETRY_EN
        exp_inh = 2;
`else
        exp_inh = 1;
`endif
        do_send(8'($urandom_range(0, 255)));
        for (int i = 0; i < 2 * (TO + INH) + 200; i++) begin
            @(negedge clk);
            if (ps2_clk_oe && !prev) inh++;
            if (!ps2_clk_oe && ps2_dat_oe && prev) t_rts = i;
            if (error) begin
                hit = 1'b1;
                lat = i - t_rts;
                oe_at_err = ps2_clk_oe | ps2_dat_oe;
                break;
            end
            prev = ps2_clk_oe;
        end
        @(negedge clk);
        nxt = error;
        checks++; if (!hit) begin failures++; $display("FAIL timeout_error got=none exp=pulse"); end
        checks++; if (lat < TO || lat > TO + 2) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d..%0d", lat, TO, TO + 2); end
        checks++; if (oe_at_err !== 1'b0) begin failures++; $display("FAIL timeout_release got=%b exp=0", oe_at_err); end
        checks++; if (inh != exp_inh) begin failures++; $display("FAIL timeout_inhibits got=%0d exp=%0d", inh, exp_inh); end
        checks++; if (nxt !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width got=%b exp=0", nxt); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [10:0] fr;
        bit ok, got, busy;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        do_send(8'hED);
        fork
            dev_frame(1'b1, fr, ok);
            begin
                repeat (INH + 8 * H) @(negedge clk);
                cmd = 8'hF4;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        checks++; if (fr !== exp_frame(8'hED)) begin failures++; $display("FAIL ignore_frame got=%h exp=%h", fr, exp_frame(8'hED)); end
        wait_result(d0, e0, got);
        checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin failures++; $display("FAIL ignore_done got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
        busy = 1'b0;
        for (int i = 0; i < 2 * INH; i++) begin
            @(negedge clk);
            busy = busy | ps2_clk_oe | ~ready;
        end
        checks++; if (busy) begin failures++; $display("FAIL ignore_queued got=busy exp=idle"); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] fr;
        logic [7:0] c;
        bit ok, got;
        int d0, e0;
        c = 8'($urandom_range(0, 255));
        d0 = done_cnt; e0 = err_cnt;
        do_send(c);
        wait_rts(ok);
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        checks++; if (ps2_dat_oe !== ~c[4]) begin failures++; $display("FAIL midreset_bit4 got=%b exp=%b", ps2_dat_oe, ~c[4]); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin failures++; $display("FAIL midreset_release got=%b%b exp=00", ps2_clk_oe, ps2_dat_oe); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", ready); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != d0 || err_cnt != e0) begin failures++; $display("FAIL midreset_pulses got=%0d/%0d exp=0/0", done_cnt - d0, err_cnt - e0); end
        c = 8'($urandom_range(0, 255));
        d0 = done_cnt; e0 = err_cnt;
        do_send(c);
        dev_frame(1'b1, fr, ok);
        checks++; if (fr !== exp_frame(c)) begin failures++; $display("FAIL midreset_next_frame got=%h exp=%h", fr, exp_frame(c)); end
        wait_result(d0, e0, got);
        checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin failures++; $display("FAIL midreset_next_done got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_exclusive;
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL done_error_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_ed;
        test_inhibit;
        test_random;
        test_nack;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
